// File: rtl/memory_stream_reader.sv
// memory_stream_reader: issues back-to-back 64-bit reads to the packet memory
// controller and streams the returned words out as valid/ready with a last
// marker. A 2-entry FIFO plus a one-deep in-flight slot bounds the buffering,
// so full throughput is kept under continuous ready and nothing is lost under
// backpressure.
module memory_stream_reader #(
    parameter int ADDR_WIDTH = 8,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  i_clk,
    input  logic                  i_areset,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH+2:0] i_start_addr,
    input  logic [LEN_WIDTH-1:0]  i_words,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_mem_read_64,
    output logic [ADDR_WIDTH-1:0] o_mem_addr_hi,
    output logic [2:0]            o_mem_addr_lo,
    input  logic                  i_mem_busy,
    input  logic [63:0]           i_mem_data,
    output logic [63:0]           o_tdata,
    output logic                  o_tvalid,
    output logic                  o_tlast,
    input  logic                  i_tready
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

    state_t                r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_addr_hi;
    logic [2:0]            r_addr_lo;
    logic [LEN_WIDTH-1:0]  r_remaining;
    logic                  r_inflight, r_inflight_last;
    logic [63:0]           r_head_data, r_tail_data;
    logic                  r_head_last, r_tail_last;
    logic [1:0]            r_count;
    logic                  r_done_req, r_done_empty;

    logic                  w_pop, w_push, w_issue, w_accept, w_accept_empty, w_finish;
    logic                  w_last_issue;
    logic [1:0]            w_occ;

    assign o_tvalid     = (r_count != 2'd0);
    assign w_pop        = o_tvalid && i_tready;
    assign w_push       = r_inflight;
    // Words already buffered plus the one that lands next cycle.
    assign w_occ        = r_count + {1'b0, r_inflight};
    assign w_last_issue = (r_remaining == LEN_WIDTH'(1));

    // State register.
    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next-state and issue decision. A slot freed by this cycle's pop may be
    // reused immediately, so issue resumes the same cycle the stream moves.
    always_comb begin
        w_state_nxt    = r_state;
        w_issue        = 1'b0;
        w_accept       = 1'b0;
        w_accept_empty = 1'b0;
        w_finish       = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Ignore a start during the completion pulse of the previous request.
                if (i_start && !r_done_req) begin
                    if (i_words != '0) begin
                        w_accept    = 1'b1;
                        w_state_nxt = S_READ;
                    end else begin
                        w_accept_empty = 1'b1;
                    end
                end
            end
            S_READ: begin
                if (!i_mem_busy && (r_remaining != '0) && ((w_occ < 2'd2) || w_pop)) begin
                    w_issue = 1'b1;
                    if (w_last_issue) w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_pop && r_head_last) begin
                    w_finish    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Read pointer and remaining count; the word address wraps silently.
    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            r_addr_hi   <= '0;
            r_addr_lo   <= '0;
            r_remaining <= '0;
        end else if (w_accept) begin
            r_addr_hi   <= i_start_addr[ADDR_WIDTH+2:3];
            r_addr_lo   <= i_start_addr[2:0];
            r_remaining <= i_words;
        end else if (w_issue) begin
            r_addr_hi   <= r_addr_hi + 1'b1;
            r_remaining <= r_remaining - 1'b1;
        end
    end

    // In-flight slot: data returns the cycle after the strobe, carrying its last tag.
    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && w_last_issue;
        end
    end

    // Two-entry FIFO built from a head register (drives the stream) and a tail register.
    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            r_head_data <= '0;
            r_head_last <= 1'b0;
            r_tail_data <= '0;
            r_tail_last <= 1'b0;
            r_count     <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_head_data <= i_mem_data;
                        r_head_last <= r_inflight_last;
                    end else begin
                        r_tail_data <= i_mem_data;
                        r_tail_last <= r_inflight_last;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    if (r_count == 2'd2) begin
                        r_head_data <= r_tail_data;
                        r_head_last <= r_tail_last;
                    end
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_head_data <= i_mem_data;
                        r_head_last <= r_inflight_last;
                    end else begin
                        r_head_data <= r_tail_data;
                        r_head_last <= r_tail_last;
                        r_tail_data <= i_mem_data;
                        r_tail_last <= r_inflight_last;
                    end
                end
                default: ;
            endcase
        end
    end

    // Completion pulses: one for a real request, one for an empty request.
    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            r_done_req   <= 1'b0;
            r_done_empty <= 1'b0;
        end else begin
            r_done_req   <= w_finish;
            r_done_empty <= w_accept_empty;
        end
    end

    // Busy covers the completion cycle of a real request but not an empty one.
    assign o_busy        = (r_state != S_IDLE) || r_done_req;
    assign o_done        = r_done_req || r_done_empty;
    assign o_mem_read_64 = w_issue;
    assign o_mem_addr_hi = r_addr_hi;
    assign o_mem_addr_lo = r_addr_lo;
    assign o_tdata       = r_head_data;
    assign o_tlast       = r_head_last && o_tvalid;

endmodule
